// File: rtl/wb_pkg.sv
// Shared widths and the write-queue entry layout for the writeback stage.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DEPTH      = 4;

  // One pending register-file write: target file, register number, value.
  typedef struct packed {
    logic                     is_reg;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding pending register-file writes.
// The head is read combinationally, so an entry pushed into an empty
// queue is visible on the write port in the very next cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int WIDTH = 1 + WB_ADDR_WIDTH + WB_DATA_WIDTH,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count_reg == CNT_W'(DEPTH));
  assign o_empty = (count_reg == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_head  = mem[rd_ptr_reg];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_reg] <= i_push_data;
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: arbitrates int-ALU/load (A) and FPU (B) results into a
// write queue, drains it to the register file, and keeps a busy scoreboard
// of registers with writes still outstanding.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rsv_valid,
  input  logic                  i_rsv_isReg,
  input  logic [ADDR_WIDTH-1:0] i_rsv_addr,
  input  logic                  i_a_valid,
  output logic                  o_a_ready,
  input  logic                  i_a_isReg,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic                  i_b_valid,
  output logic                  o_b_ready,
  input  logic                  i_b_isReg,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  input  logic                  i_wb_stall,
  input  logic                  i_qry_isreg_a,
  input  logic [ADDR_WIDTH-1:0] i_qry_addr_a,
  input  logic                  i_qry_isreg_b,
  input  logic [ADDR_WIDTH-1:0] i_qry_addr_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_doWrite,
  output logic                  o_writeisReg,
  output logic [ADDR_WIDTH-1:0] o_writeAddr,
  output logic [DATA_WIDTH-1:0] o_writeData,
  output logic                  o_full,
  output logic                  o_idle
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                  is_reg;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t              push_entry;
  entry_t              head_entry;
  logic                push_a;
  logic                push_b;
  logic                push;
  logic                empty;
  logic [NUM_REGS-1:0] busy_int_reg;
  logic [NUM_REGS-1:0] busy_flt_reg;

  // B has fixed priority; readiness looks only at current occupancy, never
  // at a same-cycle pop, so a full queue refuses pushes even while draining.
  assign o_b_ready = !o_full;
  assign o_a_ready = !o_full && !i_b_valid;
  assign push_b    = i_b_valid && o_b_ready;
  assign push_a    = i_a_valid && o_a_ready;
  assign push      = push_a || push_b;

  // Select the winning source's payload for the queue.
  always_comb begin
    push_entry = '{is_reg: i_a_isReg, addr: i_a_addr, data: i_a_data};
    if (push_b) push_entry = '{is_reg: i_b_isReg, addr: i_b_addr, data: i_b_data};
  end

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_entry),
    .i_pop       (o_doWrite),
    .o_full      (o_full),
    .o_empty     (empty),
    .o_head      (head_entry)
  );

  assign o_doWrite    = !empty && !i_wb_stall;
  assign o_writeisReg = head_entry.is_reg;
  assign o_writeAddr  = head_entry.addr;
  assign o_writeData  = head_entry.data;

  // One set/clear flop per register per file; a reservation beats a
  // retiring write to the same register on the same edge.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    logic hit_rsv;
    logic hit_wr;
    assign hit_rsv = i_rsv_valid && (i_rsv_addr == ADDR_WIDTH'(gi));
    assign hit_wr  = o_doWrite && (head_entry.addr == ADDR_WIDTH'(gi));

    // Integer-file busy bit for register gi.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                        busy_int_reg[gi] <= 1'b0;
      else if (hit_rsv && i_rsv_isReg)  busy_int_reg[gi] <= 1'b1;
      else if (hit_wr && head_entry.is_reg) busy_int_reg[gi] <= 1'b0;
    end

    // Float-file busy bit for register gi.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                         busy_flt_reg[gi] <= 1'b0;
      else if (hit_rsv && !i_rsv_isReg)  busy_flt_reg[gi] <= 1'b1;
      else if (hit_wr && !head_entry.is_reg) busy_flt_reg[gi] <= 1'b0;
    end
  end

  assign o_busy_a = i_qry_isreg_a ? busy_int_reg[i_qry_addr_a] : busy_flt_reg[i_qry_addr_a];
  assign o_busy_b = i_qry_isreg_b ? busy_int_reg[i_qry_addr_b] : busy_flt_reg[i_qry_addr_b];
  assign o_idle   = empty && (busy_int_reg == '0) && (busy_flt_reg == '0);

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the write data.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the width of register addresses.
REQ-003 Parameter DEPTH, default 4 (power of 2, at least 2), SHALL set the write-queue entry count.
REQ-004 Ports SHALL be as follows; one clock; reset asynchronous, active-high:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_rsv_valid / i_rsv_isReg / i_rsv_addr  in  1/1/ADDR_WIDTH  issue-time destination reservation (isReg 1 = int file, 0 = float file)
- i_a_valid / o_a_ready  in/out  1/1  int-ALU/load result handshake
- i_a_isReg / i_a_addr / i_a_data  in  1/ADDR_WIDTH/DATA_WIDTH  source A payload
- i_b_valid / o_b_ready  in/out  1/1  FPU result handshake
- i_b_isReg / i_b_addr / i_b_data  in  1/ADDR_WIDTH/DATA_WIDTH  source B payload
- i_wb_stall  in  1  freezes the register-file write port
- i_qry_isreg_a / i_qry_addr_a, i_qry_isreg_b / i_qry_addr_b  in  1/ADDR_WIDTH each  hazard query
- o_busy_a / o_busy_b  out  1 each  queried register has a pending write
- o_doWrite / o_writeisReg / o_writeAddr / o_writeData  out  1/1/ADDR_WIDTH/DATA_WIDTH  register-file write port
- o_full / o_idle  out  1 each  queue full / queue empty and no busy bits set

Function
REQ-005 A source transfer SHALL occur on a rising edge when its valid and ready are both 1; at most one push SHALL occur per cycle.
REQ-006 Ready SHALL be o_b_ready = !o_full and o_a_ready = !o_full && !i_b_valid, so B has fixed priority over A.
REQ-007 Ready SHALL NOT depend on a same-cycle pop; a full queue SHALL refuse pushes even while popping.
REQ-008 The queue SHALL be FIFO and track its occupancy in a count register (0..DEPTH); o_full = (count == DEPTH).
REQ-009 o_doWrite SHALL equal (count != 0) && !i_wb_stall, and o_writeisReg/o_writeAddr/o_writeData SHALL equal the head entry.
REQ-010 A pop SHALL occur on each edge where o_doWrite is 1; a simultaneous push and pop SHALL leave count unchanged.
REQ-011 Latency: an entry pushed into an empty queue at edge N SHALL appear on the write port in the cycle after edge N.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 A 2x32 busy scoreboard (int file and float file) SHALL be kept.
REQ-014 On an edge with i_rsv_valid = 1, the busy bit of the reserved register SHALL be set.
REQ-015 On each pop, the busy bit of the written register SHALL be cleared.
REQ-016 If a set and a clear hit the same bit on the same edge, the set SHALL win.
REQ-017 A pop to a register that is not busy SHALL be a legal no-op on the scoreboard; address 0 SHALL NOT be special-cased.
REQ-018 o_busy_a/o_busy_b SHALL be combinational lookups of the registered scoreboard, with no same-cycle bypass.
REQ-019 While i_wb_stall = 1, the queue SHALL hold, pushes SHALL continue until full, and busy bits SHALL NOT clear.

Reset
REQ-020 i_rst = 1 SHALL asynchronously clear the pointers, count and all busy bits.
REQ-021 During reset, o_doWrite = 0, o_full = 0, o_idle = 1, o_a_ready = 1, and o_b_ready = 1.
REQ-022 Reset asserted mid-operation SHALL discard all queued entries and reservations, and no write SHALL be issued in the following cycle.
REQ-023 Queue storage data is don't-care after reset.

Structure
REQ-024 Package wb_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, DEPTH defaults and the entry typedef {isReg, addr, data}.
REQ-025 The queue SHALL be a sub-module wb_fifo (push/pop/full/empty/head), instantiated once.
REQ-026 The scoreboard and arbitration SHALL reside in reg_writeback.

Verification
REQ-027 Single A push (isReg 1, addr 3, data 0xDEADBEEF) into an empty queue -> o_doWrite = 1 exactly one cycle later with addr 3, data 0xDEADBEEF, isReg 1.
REQ-028 A and B valid in the same cycle (A: int 5 / 0x11, B: float 5 / 0x22) -> B written first, A the cycle after, and o_a_ready = 0 in the contended cycle.
REQ-029 i_wb_stall = 1 for 6 cycles with 5 pushes offered -> 4 accepted, o_full = 1, o_b_ready = 0; after stall release, 4 writes in order on consecutive cycles.
REQ-030 Reserve float 7, then query float 7 -> o_busy = 1; after the write to float 7 pops -> o_busy = 0 the next cycle; reservation and pop of int 9 on the same edge -> int 9 stays busy.
REQ-031 Reset asserted with 3 entries queued and 2 busy bits set -> o_doWrite = 0, o_idle = 1, o_busy = 0 for all queries, with no writes after reset release.
